// File: rtl/shot_clock_pkg.sv
// Shared encodings and preset values for the shot-clock control slice.
package shot_clock_pkg;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_EXPIRED = 2'b10;

  localparam logic [7:0] PRE_24 = 8'h24;
  localparam logic [7:0] PRE_14 = 8'h14;

  // Two-digit BCD preset driven onto the counter load inputs.
  typedef struct packed {
    logic [3:0] d1;
    logic [3:0] d0;
  } preset_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-flop synchroniser, stability filter, rising-edge press pulse.
module btn_debounce #(
  parameter int unsigned DEB_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press_c
);

  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEB_CYC consecutive cycles of disagreement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYC - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Delayed level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign press_c = level & ~level_q;

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot-clock control master: preset load, per-second count enables, expiry buzzer.
module shot_clock_ctrl
  import shot_clock_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned DEB_CYC    = 500_000,
  parameter int unsigned BUZZ_TICKS = 2
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       btn_24,
  input  logic       btn_14,
  input  logic       btn_run,
  input  logic       cnt_zero,
  output logic [3:0] D1,
  output logic [3:0] D0,
  output logic       PE,
  output logic       CEP,
  output logic       CET,
  output logic       buzzer,
  output logic [1:0] state
);

  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BUZZ_LEN = BUZZ_TICKS * TICK_DIV;
  localparam int unsigned BW       = (BUZZ_LEN > 0) ? $clog2(BUZZ_LEN + 1) : 1;

  logic          press_24;
  logic          press_14;
  logic          press_run;
  logic          load_pend;
  logic [PW-1:0] pre_q;
  logic [BW-1:0] buz_q;

  logic [1:0]    state_n;
  logic [PW-1:0] pre_n;
  logic [BW-1:0] buz_n;
  preset_t       d_n;
  logic          pe_n;
  logic          cep_n;
  logic          do_load;
  logic          cz_valid;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_24 (
    .clk(CP), .rst_n(CR), .raw(btn_24), .press_c(press_24)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_14 (
    .clk(CP), .rst_n(CR), .raw(btn_14), .press_c(press_14)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_run (
    .clk(CP), .rst_n(CR), .raw(btn_run), .press_c(press_run)
  );

  // Next-state and next-output decode; a load outranks every other event.
  always_comb begin
    state_n  = state;
    pre_n    = pre_q;
    buz_n    = buz_q;
    d_n      = preset_t'({D1, D0});
    pe_n     = 1'b1;
    cep_n    = 1'b0;
    do_load  = load_pend | press_24 | press_14;
    // The counter has not absorbed a load yet while PE is low.
    cz_valid = cnt_zero & PE;
    if (do_load) begin
      pe_n  = 1'b0;
      d_n   = (load_pend | press_24) ? preset_t'(PRE_24) : preset_t'(PRE_14);
      pre_n = '0;
      if (state == ST_EXPIRED) begin
        state_n = ST_IDLE;
        buz_n   = '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (press_run && !cz_valid) state_n = ST_RUN;
        end
        ST_RUN: begin
          if (cz_valid) begin
            state_n = ST_EXPIRED;
            pre_n   = '0;
            buz_n   = BW'(BUZZ_LEN);
          end else if (press_run) begin
            state_n = ST_IDLE;
          end else if (pre_q == PW'(TICK_DIV - 1)) begin
            pre_n = '0;
            cep_n = 1'b1;
          end else begin
            pre_n = pre_q + PW'(1);
          end
        end
        ST_EXPIRED: begin
          if (buz_q != '0) buz_n = buz_q - BW'(1);
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State, timers and registered outputs.
  always_ff @(posedge CP or negedge CR) begin
    if (!CR) begin
      state     <= ST_IDLE;
      pre_q     <= '0;
      buz_q     <= '0;
      load_pend <= 1'b1;
      D1        <= 4'h2;
      D0        <= 4'h4;
      PE        <= 1'b1;
      CEP       <= 1'b0;
      CET       <= 1'b0;
      buzzer    <= 1'b0;
    end else begin
      state     <= state_n;
      pre_q     <= pre_n;
      buz_q     <= buz_n;
      load_pend <= 1'b0;
      D1        <= d_n.d1;
      D0        <= d_n.d0;
      PE        <= pe_n;
      CEP       <= cep_n;
      CET       <= (state_n == ST_RUN);
      buzzer    <= (buz_n != '0);
    end
  end

endmodule
